// File: rtl/taxi_pkg.sv
// rtl/taxi_pkg.sv - shared types and BCD helpers for the taxi fare datapath
package taxi_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SAT  = 2'b10
  } state_e;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Elaboration-time conversion of an integer constant to 8 packed BCD digits.
  function automatic logic [31:0] to_bcd32(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*BCD_W +: BCD_W] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add_n.sv
// rtl/bcd_add_n.sv - combinational N-digit ripple BCD adder with clamped input digits
module bcd_add_n
  import taxi_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [BCD_W*N-1:0] a_i,
  input  logic [BCD_W*N-1:0] b_i,
  output logic [BCD_W*N-1:0] sum_o,
  output logic               carry_o
);

  logic       carry_v;
  logic [4:0] dsum;

  always_comb begin
    carry_v = 1'b0;
    dsum    = '0;
    sum_o   = '0;
    for (int i = 0; i < N; i++) begin
      dsum = {1'b0, bcd_clamp(a_i[i*BCD_W +: BCD_W])}
           + {1'b0, bcd_clamp(b_i[i*BCD_W +: BCD_W])}
           + {4'b0, carry_v};
      if (dsum > 5'd9) begin
        dsum    = dsum - 5'd10;
        carry_v = 1'b1;
      end else begin
        carry_v = 1'b0;
      end
      sum_o[i*BCD_W +: BCD_W] = dsum[3:0];
    end
    carry_o = carry_v;
  end

endmodule

// File: rtl/distance_fare_meter.sv
// rtl/distance_fare_meter.sv - BCD distance/fare meter with free distance, day/night rate and saturation
module distance_fare_meter
  import taxi_pkg::*;
#(
  parameter int DIST_DIGITS  = 3,
  parameter int FARE_DIGITS  = 4,
  parameter int RATE_DIGITS  = 3,
  parameter int START_DIGITS = 3,
  parameter int FREE_DIST    = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ten_meter_pulse,
  input  logic                          en,
  input  logic                          clear,
  input  logic                          night,
  input  logic [BCD_W*RATE_DIGITS-1:0]  rate_day,
  input  logic [BCD_W*RATE_DIGITS-1:0]  rate_night,
  input  logic [BCD_W*START_DIGITS-1:0] s_fare,
  output logic [BCD_W*DIST_DIGITS-1:0]  distance_bcd,
  output logic [BCD_W*FARE_DIGITS-1:0]  distance_fare_bcd,
  output logic                          charging,
  output logic                          sat
);

  localparam int DW = BCD_W * DIST_DIGITS;
  localparam int FW = BCD_W * FARE_DIGITS;
  localparam logic [31:0] FREE_BCD32 = to_bcd32(FREE_DIST);
  localparam logic [DW-1:0] FREE_BCD = FREE_BCD32[DW-1:0];
  localparam logic [DW-1:0] DIST_ONE = DW'(1);
  localparam logic [DW-1:0] DIST_ALL9 = {DIST_DIGITS{4'h9}};
  localparam logic [FW-1:0] FARE_ALL9 = {FARE_DIGITS{4'h9}};

  logic          sync1_q, sync2_q, sync3_q;
  logic          pulse_evt;
  state_e        state_q, state_d;
  logic [3:0]    sub_q, sub_d;
  logic [DW-1:0] dist_q, dist_d;
  logic [FW-1:0] fare_q, fare_d;

  logic [BCD_W*RATE_DIGITS-1:0] rate_sel;
  logic [FW-1:0] rate_ext, start_ext, fare_sum;
  logic [DW-1:0] dist_sum;
  logic          fare_ovf, dist_ovf, past_free, sub_wrap;

  // sync3_q is the previous synchronised level, giving one event per rising edge.
  assign pulse_evt = sync2_q & ~sync3_q;
  assign rate_sel  = night ? rate_night : rate_day;
  assign past_free = (dist_q >= FREE_BCD);
  assign sub_wrap  = (sub_q == 4'd9);

  always_comb begin
    rate_ext  = '0;
    start_ext = '0;
    rate_ext[BCD_W*RATE_DIGITS-1:0]   = rate_sel;
    start_ext[BCD_W*START_DIGITS-1:0] = s_fare;
  end

  bcd_add_n #(.N(FARE_DIGITS)) u_fare_add (
    .a_i     (fare_q),
    .b_i     (rate_ext),
    .sum_o   (fare_sum),
    .carry_o (fare_ovf)
  );

  bcd_add_n #(.N(DIST_DIGITS)) u_dist_add (
    .a_i     (dist_q),
    .b_i     (DIST_ONE),
    .sum_o   (dist_sum),
    .carry_o (dist_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      state_q <= ST_IDLE;
      sub_q   <= '0;
      dist_q  <= '0;
      fare_q  <= '0;
    end else begin
      sync1_q <= ten_meter_pulse;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      state_q <= state_d;
      sub_q   <= sub_d;
      dist_q  <= dist_d;
      fare_q  <= fare_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    dist_d  = dist_q;
    fare_d  = fare_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en || clear) begin
          state_d = ST_RUN;
          sub_d   = '0;
          dist_d  = '0;
          fare_d  = start_ext;
        end
      end
      ST_RUN: begin
        if (clear) begin
          sub_d  = '0;
          dist_d = '0;
          fare_d = start_ext;
        end else if (pulse_evt && en) begin
          if (sub_wrap) begin
            sub_d  = '0;
            dist_d = dist_ovf ? DIST_ALL9 : dist_sum;
          end else begin
            sub_d = sub_q + 4'd1;
          end
          // Free distance is judged on the distance before this pulse.
          if (past_free) begin
            fare_d = fare_ovf ? FARE_ALL9 : fare_sum;
          end
          if ((sub_wrap && dist_ovf) || (past_free && fare_ovf)) begin
            state_d = ST_SAT;
          end
        end
      end
      ST_SAT: begin
        if (clear) begin
          state_d = ST_RUN;
          sub_d   = '0;
          dist_d  = '0;
          fare_d  = start_ext;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign distance_bcd      = dist_q;
  assign distance_fare_bcd = fare_q;
  assign charging          = (state_q != ST_IDLE) && past_free;
  assign sat               = (state_q == ST_SAT);

endmodule

// File: tb/tb_distance_fare_meter.sv
// tb/tb_distance_fare_meter.sv - self-checking bench for distance_fare_meter against an integer model
module tb_distance_fare_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ten_meter_pulse, en, clear, night;
  logic [11:0] rate_day, rate_night, s_fare;
  logic [11:0] d0_dist;
  logic [15:0] d0_fare;
  logic        d0_chg, d0_sat;
  logic [3:0]  d1_dist;
  logic [15:0] d1_fare;
  logic        d1_chg, d1_sat;

  distance_fare_meter u_dut0 (
    .clk(clk), .rst_n(rst_n), .ten_meter_pulse(ten_meter_pulse), .en(en), .clear(clear),
    .night(night), .rate_day(rate_day), .rate_night(rate_night), .s_fare(s_fare),
    .distance_bcd(d0_dist), .distance_fare_bcd(d0_fare), .charging(d0_chg), .sat(d0_sat)
  );

  distance_fare_meter #(.DIST_DIGITS(1), .FREE_DIST(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ten_meter_pulse(ten_meter_pulse), .en(en), .clear(clear),
    .night(night), .rate_day(rate_day), .rate_night(rate_night), .s_fare(s_fare),
    .distance_bcd(d1_dist), .distance_fare_bcd(d1_fare), .charging(d1_chg), .sat(d1_sat)
  );

  logic [15:0] obs_dist[2];
  logic [15:0] obs_fare[2];
  logic        obs_chg[2];
  logic        obs_sat[2];

  always_comb begin
    obs_dist[0] = {4'h0, d0_dist};
    obs_dist[1] = {12'h0, d1_dist};
    obs_fare[0] = d0_fare;
    obs_fare[1] = d1_fare;
    obs_chg[0]  = d0_chg;
    obs_chg[1]  = d1_chg;
    obs_sat[0]  = d0_sat;
    obs_sat[1]  = d1_sat;
  end

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 run, 2 saturated; values kept as plain integers.
  int m_mode[2], m_sub[2], m_dist[2], m_fare[2];
  int m_free[2] = '{30, 0};
  int m_dmax[2] = '{999, 9};
  localparam int FARE_MAX = 9999;

  function automatic int bcd_val(input logic [11:0] v);
    int r = 0;
    int p = 1;
    int d;
    for (int i = 0; i < 3; i++) begin
      d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int_bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_load(input int k);
    m_mode[k] = 1;
    m_sub[k]  = 0;
    m_dist[k] = 0;
    m_fare[k] = bcd_val(s_fare);
  endtask

  task automatic model_pulse();
    bit ovf;
    bit was_free;
    int f;
    for (int k = 0; k < 2; k++) begin
      if (m_mode[k] == 1 && en) begin
        ovf = 0;
        was_free = (m_dist[k] >= m_free[k]);
        if (m_sub[k] == 9) begin
          m_sub[k] = 0;
          if (m_dist[k] + 1 > m_dmax[k]) begin
            m_dist[k] = m_dmax[k];
            ovf = 1;
          end else begin
            m_dist[k] = m_dist[k] + 1;
          end
        end else begin
          m_sub[k] = m_sub[k] + 1;
        end
        if (was_free) begin
          f = m_fare[k] + bcd_val(night ? rate_night : rate_day);
          if (f > FARE_MAX) begin
            f = FARE_MAX;
            ovf = 1;
          end
          m_fare[k] = f;
        end
        if (ovf) m_mode[k] = 2;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    clear = 1'b0;
    ten_meter_pulse = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_sub[k] = 0; m_dist[k] = 0; m_fare[k] = 0;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) if (m_mode[k] == 0) model_load(k);
  endtask

  task automatic do_pulse();
    @(negedge clk);
    ten_meter_pulse = 1'b1;
    repeat (4) @(negedge clk);
    ten_meter_pulse = 1'b0;
    repeat (4) @(negedge clk);
    model_pulse();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int k = 0; k < 2; k++) model_load(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; clear = 1'b0; night = 1'b0; ten_meter_pulse = 1'b0;
    rate_day = '0; rate_night = '0; s_fare = '0;
    repeat (2) @(negedge clk);
    checks++; if (d0_dist !== 12'h000) begin errors++; $display("FAIL reset_d0_dist got %h want 000", d0_dist); end
    checks++; if (d0_fare !== 16'h0000) begin errors++; $display("FAIL reset_d0_fare got %h want 0000", d0_fare); end
    checks++; if (d0_chg !== 1'b0) begin errors++; $display("FAIL reset_d0_chg got %b want 0", d0_chg); end
    checks++; if (d0_sat !== 1'b0) begin errors++; $display("FAIL reset_d0_sat got %b want 0", d0_sat); end
    checks++; if (d1_dist !== 4'h0) begin errors++; $display("FAIL reset_d1_dist got %h want 0", d1_dist); end
    checks++; if (d1_fare !== 16'h0000) begin errors++; $display("FAIL reset_d1_fare got %h want 0000", d1_fare); end
    checks++; if (d1_chg !== 1'b0) begin errors++; $display("FAIL reset_d1_chg got %b want 0 (idle)", d1_chg); end
    checks++; if (d1_sat !== 1'b0) begin errors++; $display("FAIL reset_d1_sat got %b want 0", d1_sat); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_sub[k] = 0; m_dist[k] = 0; m_fare[k] = 0;
    end
  endtask

  task automatic test_basic();
    do_reset();
    s_fare = 12'h300; rate_day = 12'h003; night = 1'b0;
    start_run();
    repeat (10) do_pulse();
    checks++; if (d1_dist !== 4'h1) begin errors++; $display("FAIL basic_dist got %h want 1", d1_dist); end
    checks++; if (d1_fare !== 16'h0330) begin errors++; $display("FAIL basic_fare got %h want 0330", d1_fare); end
    checks++; if (d1_chg !== 1'b1) begin errors++; $display("FAIL basic_chg got %b want 1", d1_chg); end
    checks++; if (d0_dist !== 12'h001) begin errors++; $display("FAIL basic_free_dist got %h want 001", d0_dist); end
    checks++; if (d0_fare !== 16'h0300) begin errors++; $display("FAIL basic_free_fare got %h want 0300", d0_fare); end
    checks++; if (d0_chg !== 1'b0) begin errors++; $display("FAIL basic_free_chg got %b want 0", d0_chg); end
  endtask

  task automatic test_free_distance();
    do_reset();
    s_fare = 12'h300; rate_day = 12'h003; rate_night = 12'h004; night = 1'b0;
    start_run();
    repeat (300) do_pulse();
    checks++; if (d0_dist !== 12'h030) begin errors++; $display("FAIL free_dist got %h want 030", d0_dist); end
    checks++; if (d0_fare !== 16'h0300) begin errors++; $display("FAIL free_fare300 got %h want 0300", d0_fare); end
    checks++; if (d0_chg !== 1'b1) begin errors++; $display("FAIL free_chg got %b want 1", d0_chg); end
    do_pulse();
    checks++; if (d0_fare !== 16'h0303) begin errors++; $display("FAIL free_fare301 got %h want 0303", d0_fare); end
    night = 1'b1;
    do_pulse();
    checks++; if (d0_fare !== 16'h0307) begin errors++; $display("FAIL night_fare302 got %h want 0307", d0_fare); end
    checks++; if (d1_fare !== 16'h0600) begin errors++; $display("FAIL free_d1_fare got %h want 0600", d1_fare); end
    checks++; if (d1_sat !== 1'b1) begin errors++; $display("FAIL free_d1_sat got %b want 1", d1_sat); end
    night = 1'b0;
  endtask

  task automatic test_enable();
    do_reset();
    s_fare = 12'h300; rate_day = 12'h005; night = 1'b0;
    repeat (3) do_pulse();
    checks++; if (d0_fare !== 16'h0000) begin errors++; $display("FAIL idle_fare got %h want 0000", d0_fare); end
    checks++; if (d0_dist !== 12'h000) begin errors++; $display("FAIL idle_dist got %h want 000", d0_dist); end
    checks++; if (d1_chg !== 1'b0) begin errors++; $display("FAIL idle_chg got %b want 0", d1_chg); end
    start_run();
    checks++; if (d0_fare !== 16'h0300) begin errors++; $display("FAIL en_exit_fare got %h want 0300", d0_fare); end
    repeat (7) do_pulse();
    @(negedge clk);
    en = 1'b0;
    repeat (5) do_pulse();
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_dist[k] !== int_bcd(m_dist[k])) begin errors++; $display("FAIL gate_dist dut%0d got %h want %h", k, obs_dist[k], int_bcd(m_dist[k])); end
      checks++; if (obs_fare[k] !== int_bcd(m_fare[k])) begin errors++; $display("FAIL gate_fare dut%0d got %h want %h", k, obs_fare[k], int_bcd(m_fare[k])); end
    end
    checks++; if (d1_fare !== 16'h0335) begin errors++; $display("FAIL gate_hold got %h want 0335", d1_fare); end
  endtask

  task automatic test_fare_sat();
    do_reset();
    s_fare = 12'h999; rate_day = 12'h999; night = 1'b0;
    start_run();
    repeat (9) do_pulse();
    checks++; if (d1_fare !== 16'h9990) begin errors++; $display("FAIL fsat_pre got %h want 9990", d1_fare); end
    checks++; if (d1_sat !== 1'b0) begin errors++; $display("FAIL fsat_pre_sat got %b want 0", d1_sat); end
    do_pulse();
    checks++; if (d1_fare !== 16'h9999) begin errors++; $display("FAIL fsat_fare got %h want 9999", d1_fare); end
    checks++; if (d1_sat !== 1'b1) begin errors++; $display("FAIL fsat_flag got %b want 1", d1_sat); end
    repeat (2) do_pulse();
    checks++; if (d1_fare !== 16'h9999) begin errors++; $display("FAIL fsat_hold got %h want 9999", d1_fare); end
    checks++; if (d1_dist !== 4'h1) begin errors++; $display("FAIL fsat_dist got %h want 1", d1_dist); end
    do_clear();
    checks++; if (d1_fare !== 16'h0999) begin errors++; $display("FAIL fsat_clear_fare got %h want 0999", d1_fare); end
    checks++; if (d1_sat !== 1'b0) begin errors++; $display("FAIL fsat_clear_sat got %b want 0", d1_sat); end
    checks++; if (d1_dist !== 4'h0) begin errors++; $display("FAIL fsat_clear_dist got %h want 0", d1_dist); end
  endtask

  task automatic test_dist_sat();
    do_reset();
    s_fare = 12'h000; rate_day = 12'h001; night = 1'b0;
    start_run();
    repeat (99) do_pulse();
    checks++; if (d1_dist !== 4'h9) begin errors++; $display("FAIL dsat_pre_dist got %h want 9", d1_dist); end
    checks++; if (d1_sat !== 1'b0) begin errors++; $display("FAIL dsat_pre_sat got %b want 0", d1_sat); end
    do_pulse();
    checks++; if (d1_dist !== 4'h9) begin errors++; $display("FAIL dsat_dist got %h want 9", d1_dist); end
    checks++; if (d1_fare !== 16'h0100) begin errors++; $display("FAIL dsat_fare got %h want 0100", d1_fare); end
    checks++; if (d1_sat !== 1'b1) begin errors++; $display("FAIL dsat_flag got %b want 1", d1_sat); end
  endtask

  task automatic test_priority();
    do_reset();
    s_fare = 12'h250; rate_day = 12'h007; night = 1'b0;
    start_run();
    repeat (3) do_pulse();
    // Raise the pulse, then hold clear on the cycle its synchronised event arrives.
    @(negedge clk);
    ten_meter_pulse = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    ten_meter_pulse = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) model_load(k);
    checks++; if (d1_fare !== 16'h0250) begin errors++; $display("FAIL prio_fare got %h want 0250", d1_fare); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (obs_dist[k] !== int_bcd(m_dist[k])) begin errors++; $display("FAIL prio_dist dut%0d got %h want %h", k, obs_dist[k], int_bcd(m_dist[k])); end
      checks++; if (obs_sat[k] !== (m_mode[k] == 2)) begin errors++; $display("FAIL prio_sat dut%0d got %b want %b", k, obs_sat[k], m_mode[k] == 2); end
    end
    repeat (2) do_pulse();
    @(negedge clk);
    ten_meter_pulse = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (d1_fare !== 16'h0000) begin errors++; $display("FAIL arst_fare got %h want 0000", d1_fare); end
    checks++; if (d1_chg !== 1'b0) begin errors++; $display("FAIL arst_chg got %b want 0", d1_chg); end
    checks++; if (d0_fare !== 16'h0000) begin errors++; $display("FAIL arst_d0_fare got %h want 0000", d0_fare); end
    @(negedge clk);
    ten_meter_pulse = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_sub[k] = 0; m_dist[k] = 0; m_fare[k] = 0;
    end
    do_pulse();
    checks++; if (d1_fare !== 16'h0000) begin errors++; $display("FAIL post_rst_fare got %h want 0000", d1_fare); end
    checks++; if (d1_chg !== 1'b0) begin errors++; $display("FAIL post_rst_chg got %b want 0", d1_chg); end
    checks++; if (d1_dist !== 4'h0) begin errors++; $display("FAIL post_rst_dist got %h want 0", d1_dist); end
  endtask

  task automatic test_random();
    logic [15:0] sf;
    bit exp_chg;
    do_reset();
    sf = int_bcd($urandom_range(0, 999));
    s_fare = sf[11:0];
    start_run();
    for (int it = 0; it < 200; it++) begin
      rate_day   = 12'($urandom);
      rate_night = 12'($urandom);
      night      = 1'($urandom);
      en         = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) begin
        sf = int_bcd($urandom_range(0, 999));
        s_fare = sf[11:0];
        do_clear();
      end else begin
        do_pulse();
      end
      for (int k = 0; k < 2; k++) begin
        exp_chg = (m_mode[k] != 0) && (m_dist[k] >= m_free[k]);
        checks++; if (obs_dist[k] !== int_bcd(m_dist[k])) begin errors++; $display("FAIL rnd_dist it%0d dut%0d got %h want %h", it, k, obs_dist[k], int_bcd(m_dist[k])); end
        checks++; if (obs_fare[k] !== int_bcd(m_fare[k])) begin errors++; $display("FAIL rnd_fare it%0d dut%0d got %h want %h", it, k, obs_fare[k], int_bcd(m_fare[k])); end
        checks++; if (obs_chg[k] !== exp_chg) begin errors++; $display("FAIL rnd_chg it%0d dut%0d got %b want %b", it, k, obs_chg[k], exp_chg); end
        checks++; if (obs_sat[k] !== (m_mode[k] == 2)) begin errors++; $display("FAIL rnd_sat it%0d dut%0d got %b want %b", it, k, obs_sat[k], m_mode[k] == 2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_free_distance();
    test_enable();
    test_fare_sat();
    test_dist_sat();
    test_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/distance_fare_meter.md
# distance_fare_meter

Parametrised successor to the per-pulse distance fare counter. It runs on the system clock and treats `ten_meter_pulse` as an asynchronous strobe, which it synchronises and edge-detects. It accumulates travelled distance and fare in multi-digit BCD, with:
- a free distance covered by the start fare,
- day/night rate selection,
- trip clear,
- saturation with a status flag.

It sits between the wheel-sensor pulse shaper and the display/billing mux.

## Interface
Parameters:
- `DIST_DIGITS`, default 3: BCD digits of distance, in 0.1 km units.
- `FARE_DIGITS`, default 4: BCD digits of the fare accumulator.
- `RATE_DIGITS`, default 3: BCD digits of each per-pulse rate. Must be ≤ `FARE_DIGITS`.
- `START_DIGITS`, default 3: BCD digits of the start fare. Must be ≤ `FARE_DIGITS`.
- `FREE_DIST`, default 30: free distance in 0.1 km units. Must be < 10^`DIST_DIGITS`.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. **Asynchronous, active-low.**
- `ten_meter_pulse`, input, 1: asynchronous strobe; one rising edge per 10 m.
- `en`, input, 1: counting enable. Level, synchronous to `clk`.
- `clear`, input, 1: start new trip. Single-cycle, synchronous.
- `night`, input, 1: 1 selects `rate_night`, 0 selects `rate_day`. Sampled per counted pulse.
- `rate_day`, input, 4·`RATE_DIGITS`: BCD fare added per counted pulse, day.
- `rate_night`, input, 4·`RATE_DIGITS`: BCD fare added per counted pulse, night.
- `s_fare`, input, 4·`START_DIGITS`: BCD start fare.
- `distance_bcd`, output, 4·`DIST_DIGITS`: distance in 0.1 km.
- `distance_fare_bcd`, output, 4·`FARE_DIGITS`: current fare.
- `charging`, output, 1: distance ≥ `FREE_DIST`.
- `sat`, output, 1: a counter has saturated.

## Operation
Input sync:
- `ten_meter_pulse` passes through a 2-flop synchroniser, then a rising-edge detector, producing internal `pulse_evt`.
- One event per rising edge, regardless of pulse width.

States:
- **IDLE**
  - Outputs: distance 0, fare 0, `charging` 0, `sat` 0.
  - If `en`=1 or `clear`=1: load fare ← zero-extended `s_fare`, distance and sub-counter ← 0, go to RUN.
- **RUN**
  - Each `pulse_evt` with `en`=1 is a counted pulse.
  - A sub-counter runs 0..9. At 9 it wraps to 0 and distance increments by 0.1 km. Otherwise the sub-counter increments.
  - If distance ≥ `FREE_DIST` *before* the pulse, fare += selected rate (zero-extended).
  - With `en`=0, events are dropped and all values hold.
  - `clear`: reload as in IDLE and stay in RUN.
- **SAT**
  - Entered when a counted pulse would overflow the fare or the distance.
  - The overflowing counter is forced to all 9s. The other counter takes its normal update.
  - `sat`=1. All further pulses are ignored.
  - Exit only via `clear` (reload, go to RUN) or reset.

Arithmetic:
- Full ripple BCD addition per digit: sum > 9 ⇒ subtract 10, carry 1.
- Overflow is the carry out of the top digit.
- Input digits > 9 are clamped to 9 before addition.

Priority:
- Reset > `clear` > counted pulse.
- `clear` and `pulse_evt` in the same cycle: clear wins and the pulse is lost.

`charging` is combinational from the registered distance.

## Timing
- Reset value of every output is 0. State resets to IDLE, sub-counter to 0, sync flops to 0.
- Latency, pin to output: a rising edge on `ten_meter_pulse` is reflected on the outputs at the 3rd `clk` rising edge after it. That is 2 sync stages plus 1 register stage.
- `clear` to reload: 1 cycle.
- `night` and the rates are sampled in the cycle `pulse_evt` is asserted.
- Minimum pulse spacing is 4 `clk` cycles high and 4 low. Faster input is undefined.
- Reset mid-trip: outputs go to 0 immediately (asynchronous). After release the block is in IDLE.

## Structure
Shared package `taxi_pkg`:
- `BCD_W` = 4.
- State encoding: IDLE=2'b00, RUN=2'b01, SAT=2'b10.
- Clamp helper function for BCD digits.

Sub-module `bcd_add_n`:
- Combinational, parameter `N` digits.
- Outputs: sum and carry-out.
- Instantiated twice: once for fare, once for distance +1.

Pulse synchroniser and edge detector are inline.

## Test plan
1. **Basic charging.** `FREE_DIST`=0, `s_fare`=0x300, `rate_day`=0x003, `en`=1, 10 pulses → `distance_bcd`=0x001, fare=0x0330, `charging`=1.
2. **Free distance.** Defaults, 300 pulses → distance=0x030, fare=0x0300. Pulse 301 → fare=0x0303. Toggle `night`=1 with `rate_night`=0x004, pulse 302 → fare=0x0307.
3. **Enable gating and IDLE exit.** `en`=0 after reset, pulses → outputs stay 0 and state stays IDLE. `en`=1 → fare=0x0300 at the next edge. Drop `en` mid-run, 5 pulses → values unchanged.
4. **Fare saturation.** `s_fare`=0x999, `FREE_DIST`=0, rate=0x999, with fare at 0x9990 plus one pulse → fare=0x9999, `sat`=1. Further pulses → no change. `clear` → fare=0x0999, `sat`=0.
5. **Distance saturation.** `DIST_DIGITS`=1, 100 pulses → distance=0x9, `sat`=1. Fare still adds on the saturating pulse.
6. **Priority and reset.** `clear` coincident with `pulse_evt` → reload, pulse not counted. Assert `rst_n`=0 mid-pulse-stream → all outputs 0 within the same cycle. After release the block is in IDLE.
